dcache_tag_array_nway: RTL
==========================

Name: dcache_tag_array_nway

Overview:
Parametrised N-way set-associative tag array for the data cache. It stores the tag and valid bit of every way, compares all ways in parallel one cycle after a lookup, and reports hit, hit way and replacement victim. Valid bits live in the same RAM word as the tag, so the array is block-RAM friendly. Clearing the array on reset or flush is therefore done by a sequential walk over all sets.

Parameters:
NUM_WAYS, 4, associativity; power of two, at least 1
NUM_SETS, 256, number of cache indexes; power of two, at least 2
TAG_WIDTH, 20, tag bits per way
IDX_W, $clog2(NUM_SETS), derived set-index width
WAY_W, max(1,$clog2(NUM_WAYS)), derived way-index width

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
req_valid_i  in  1  lookup request
req_ready_o  out  1  lookup accepted when valid&ready
req_index_i  in  IDX_W  lookup set
req_tag_i  in  TAG_WIDTH  lookup compare tag
rsp_valid_o  out  1  lookup result valid, one cycle after accept
rsp_hit_o  out  1  tag matched a valid way
rsp_hit_way_o  out  WAY_W  matching way
rsp_victim_way_o  out  WAY_W  way to refill on a miss
upd_valid_i  in  1  update request
upd_ready_o  out  1  update accepted when valid&ready
upd_op_i  in  1  0 = refill (write tag, set valid); 1 = invalidate (clear valid)
upd_index_i  in  IDX_W  update set
upd_way_i  in  WAY_W  update way
upd_tag_i  in  TAG_WIDTH  refill tag (ignored for invalidate)
flush_i  in  1  single-cycle pulse: invalidate the whole array
busy_o  out  1  high while in INIT or FLUSH
flush_done_o  out  1  one-cycle pulse when a flush walk completes

Behaviour:
- FSM states: INIT, IDLE, FLUSH.
  - rst_i forces INIT and clears the walk counter.
  - INIT and FLUSH write the all-invalid pattern (every valid bit 0, round-robin pointer 0) to set = counter, one set per cycle, counter 0..NUM_SETS-1.
  - After the write to set NUM_SETS-1, the FSM goes to IDLE.
  - INIT→IDLE takes exactly NUM_SETS cycles after reset deassertion, with no flush_done_o pulse.
  - FLUSH→IDLE raises flush_done_o for exactly 1 cycle, coinciding with the first IDLE cycle.
- Reset values: req_ready_o=0, upd_ready_o=0, rsp_valid_o=0, rsp_hit_o=0, rsp_hit_way_o=0, rsp_victim_way_o=0, busy_o=1, flush_done_o=0.
- req_ready_o = upd_ready_o = (state==IDLE) & !flush_i. busy_o = (state!=IDLE).
- flush_i:
  - Sampled only in IDLE; ignored during INIT and FLUSH.
  - A lookup or update presented in the same cycle as flush_i is not accepted.
  - A lookup accepted in the cycle before flush_i still gets its response, against pre-flush contents.
- Lookup, 1-cycle latency:
  - Accepted at edge N; at N+1, rsp_valid_o=1 for one cycle.
  - rsp_hit_o = OR over ways of (valid & tag==req_tag).
  - rsp_hit_way_o = lowest matching way, 0 on miss.
  - The set is read on accept. Outputs hold their last values when rsp_valid_o=0.
- Victim selection (computed every response):
  - If any way of the set is invalid, the lowest-numbered invalid way.
  - Otherwise the set's round-robin pointer.
- Round-robin pointer, WAY_W bits per set:
  - On every accepted refill it becomes (upd_way_i+1) mod NUM_WAYS.
  - Invalidate does not change it.
- Update:
  - Accepted at edge N, written at edge N.
  - Refill writes upd_tag_i and sets valid of upd_way_i.
  - Invalidate clears valid of upd_way_i and leaves the tag unchanged.
  - Other ways of the set are untouched.
- Simultaneous accepted lookup and update to the same set: write-first. The response at N+1 reflects the post-update contents, including the victim and pointer.
- NUM_WAYS=1: rsp_hit_way_o and rsp_victim_way_o are always 0.
- Reset mid-operation (any state): returns to INIT. Any pending response is discarded (rsp_valid_o=0 next cycle).

Test Plan:
- Reset, NUM_SETS=256: busy_o high for exactly 256 cycles, then ready. Lookup set 0x10 tag 0x12345 → rsp_valid_o at +1, hit=0, victim=0.
- Refill set 5 ways 0..3 with tags 0xA..0xD, then look up 0xC at set 5 → hit=1, hit_way=2. Look up 0xE → hit=0, victim=0 (pointer wrapped after way 3).
- Invalidate set 5 way 1, then look up 0xB → miss, victim=1. Refill 0xE way 1; next lookup of 0xE hits way 1.
- Lookup of set 7 tag 0x55 in the same cycle as a refill of set 7 way 0 tag 0x55 → response hit=1, way 0 (write-first).
- Fill several sets, pulse flush_i → ready low for 256 cycles and flush_done_o pulses once. All prior tags miss afterwards, and flush_i during FLUSH has no effect.
- Assert rst_i midway through a flush and during a pending lookup → no rsp_valid_o and no flush_done_o. Full 256-cycle INIT, then the array is empty.

Source files
------------

// File: rtl/dcache_tag_array_nway.sv
// N-way set-associative tag array: per-way {valid, tag} RAMs plus a per-set
// round-robin pointer RAM, parallel compare one cycle after lookup accept.
module dcache_tag_array_nway #(
  parameter int NUM_WAYS  = 4,
  parameter int NUM_SETS  = 256,
  parameter int TAG_WIDTH = 20,
  localparam int IDX_W    = $clog2(NUM_SETS),
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [IDX_W-1:0]     req_index_i,
  input  logic [TAG_WIDTH-1:0] req_tag_i,
  output logic                 rsp_valid_o,
  output logic                 rsp_hit_o,
  output logic [WAY_W-1:0]     rsp_hit_way_o,
  output logic [WAY_W-1:0]     rsp_victim_way_o,
  input  logic                 upd_valid_i,
  output logic                 upd_ready_o,
  input  logic                 upd_op_i,
  input  logic [IDX_W-1:0]     upd_index_i,
  input  logic [WAY_W-1:0]     upd_way_i,
  input  logic [TAG_WIDTH-1:0] upd_tag_i,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic                 flush_done_o
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FLUSH} state_t;

  state_t               state_reg;
  logic [IDX_W-1:0]     cnt_reg;
  logic                 flush_done_reg;
  logic                 rsp_valid_reg;
  logic [TAG_WIDTH-1:0] rsp_tag_reg;
  logic [WAY_W-1:0]     rr_rd_reg;
  logic [WAY_W-1:0]     rr_mem [NUM_SETS];

  logic [NUM_WAYS-1:0]  way_valid;
  logic [TAG_WIDTH-1:0] way_tag [NUM_WAYS];

  logic                 idle;
  logic                 accept_ok;
  logic                 req_fire;
  logic                 upd_fire;
  logic                 refill_fire;
  logic                 walk_we;
  logic                 same_set;
  logic [WAY_W-1:0]     rr_next;

  logic                 hit_comb;
  logic [WAY_W-1:0]     hit_way_comb;
  logic [WAY_W-1:0]     victim_comb;

  assign idle        = (state_reg == ST_IDLE);
  assign accept_ok   = idle && !flush_i;
  assign req_ready_o = accept_ok;
  assign upd_ready_o = accept_ok;
  assign req_fire    = req_valid_i && accept_ok;
  assign upd_fire    = upd_valid_i && accept_ok;
  assign refill_fire = upd_fire && !upd_op_i;
  assign walk_we     = !idle;
  assign same_set    = upd_fire && (upd_index_i == req_index_i);
  // NUM_WAYS is a power of two, so the increment wraps on its own
  assign rr_next     = (NUM_WAYS == 1) ? '0 : upd_way_i + WAY_W'(1);

  assign busy_o       = !idle;
  assign flush_done_o = flush_done_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_INIT;
      cnt_reg        <= '0;
      flush_done_reg <= 1'b0;
    end else begin
      flush_done_reg <= 1'b0;
      case (state_reg)
        ST_INIT, ST_FLUSH: begin
          cnt_reg <= cnt_reg + IDX_W'(1);
          if (cnt_reg == IDX_W'(NUM_SETS - 1)) begin
            state_reg      <= ST_IDLE;
            flush_done_reg <= (state_reg == ST_FLUSH);
          end
        end
        ST_IDLE: begin
          if (flush_i) begin
            state_reg <= ST_FLUSH;
            cnt_reg   <= '0;
          end
        end
        default: begin
          state_reg <= ST_INIT;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (walk_we) begin
      rr_mem[cnt_reg] <= '0;
    end else if (refill_fire) begin
      rr_mem[upd_index_i] <= rr_next;
    end
  end

  // Same-set refill bypasses the RAM so the response sees post-update state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_reg <= 1'b0;
      rsp_tag_reg   <= '0;
      rr_rd_reg     <= '0;
    end else begin
      rsp_valid_reg <= req_fire;
      if (req_fire) begin
        rsp_tag_reg <= req_tag_i;
        rr_rd_reg   <= (same_set && !upd_op_i) ? rr_next : rr_mem[req_index_i];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
    logic [TAG_WIDTH:0] tag_mem [NUM_SETS];
    logic [TAG_WIDTH:0] rd_reg;
    logic               way_sel;

    assign way_sel = (NUM_WAYS == 1) || (upd_way_i == WAY_W'(gi));

    always_ff @(posedge clk_i) begin
      if (walk_we) begin
        tag_mem[cnt_reg] <= '0;
      end else if (upd_fire && way_sel) begin
        if (upd_op_i) begin
          tag_mem[upd_index_i][TAG_WIDTH] <= 1'b0;
        end else begin
          tag_mem[upd_index_i] <= {1'b1, upd_tag_i};
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rd_reg <= '0;
      end else if (req_fire) begin
        if (same_set && way_sel) begin
          rd_reg <= {!upd_op_i,
                     upd_op_i ? tag_mem[req_index_i][TAG_WIDTH-1:0] : upd_tag_i};
        end else begin
          rd_reg <= tag_mem[req_index_i];
        end
      end
    end

    assign way_valid[gi] = rd_reg[TAG_WIDTH];
    assign way_tag[gi]   = rd_reg[TAG_WIDTH-1:0];
  end

  // Descending scan: the last assignment made is the lowest-numbered way
  always_comb begin
    hit_comb     = 1'b0;
    hit_way_comb = '0;
    victim_comb  = rr_rd_reg;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (way_valid[w] && (way_tag[w] == rsp_tag_reg)) begin
        hit_comb     = 1'b1;
        hit_way_comb = WAY_W'(w);
      end
      if (!way_valid[w]) begin
        victim_comb = WAY_W'(w);
      end
    end
  end

  assign rsp_valid_o      = rsp_valid_reg;
  assign rsp_hit_o        = hit_comb;
  assign rsp_hit_way_o    = hit_way_comb;
  assign rsp_victim_way_o = victim_comb;

endmodule
